// File: rtl/frame_capture_ctrl_pkg.sv
// Shared definitions for the frame capture controller: FSM state encodings
// and the default frame geometry.
package frame_capture_ctrl_pkg;

   typedef enum logic [1:0] {
      S_LIVE    = 2'b00,
      S_ARM     = 2'b01,
      S_CAPTURE = 2'b10,
      S_FROZEN  = 2'b11
   } state_e;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int DECIM_DEF    = 2;
   localparam int ADDR_W_DEF   = 17;

endpackage : frame_capture_ctrl_pkg

// File: rtl/frame_capture_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A request held high produces exactly one single-cycle pulse; the pulse
// is visible three clocks after the asynchronous input rises.
module frame_capture_ctrl_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic async_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic pulse_q;

   // Synchronize, remember the previous synchronized level, register the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         meta_q  <= async_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         pulse_q <= sync_q & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule : frame_capture_ctrl_sync_edge

// File: rtl/frame_capture_ctrl.sv
// Single-frame capture sequencer. Generates frame-buffer write/read
// addresses from the incoming row/col timing, captures one decimated frame
// on request and then holds the VGA output on the stored frame until a
// return-to-live request arrives. The FSM state is exported on 'state'.
module frame_capture_ctrl
   import frame_capture_ctrl_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int DECIM    = DECIM_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vsync_n,
   input  logic [12:0]       row,
   input  logic [12:0]       col,
   input  logic              capture_req,
   input  logic              live_req,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic              freeze,
   output logic [1:0]        state,
   output logic [7:0]        frame_cnt,
   output logic              short_frame
);

   localparam int LOG2_DECIM = $clog2(DECIM);
   localparam int LINE_W     = H_ACTIVE / DECIM;
   localparam int DEPTH      = LINE_W * (V_ACTIVE / DECIM);
   localparam int CNT_W      = ADDR_W + 1;

   localparam logic [12:0]       H_ACT_C    = 13'(H_ACTIVE);
   localparam logic [12:0]       V_ACT_C    = 13'(V_ACTIVE);
   localparam logic [12:0]       DEC_MASK_C = 13'(DECIM - 1);
   localparam logic [ADDR_W-1:0] LINE_W_C   = ADDR_W'(LINE_W);
   localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

   logic cap_pulse;
   logic live_pulse;

   logic              vs_prev_q;
   logic              frame_start;
   logic              act;
   logic              on_grid;
   logic [ADDR_W-1:0] addr;
   logic              wr_fire;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]  wr_cnt_inc;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic              short_q, short_d;
   logic              freeze_q;

   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              rd_valid_q;

   frame_capture_ctrl_sync_edge u_cap_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (capture_req),
      .pulse_o (cap_pulse)
   );

   frame_capture_ctrl_sync_edge u_live_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (live_req),
      .pulse_o (live_pulse)
   );

   // Pixel qualification and buffer address; the multiply is by a constant
   // line width so it reduces to shifts and adds.
   always_comb begin
      act         = (row < V_ACT_C) && (col < H_ACT_C);
      on_grid     = ((row & DEC_MASK_C) == 13'd0) && ((col & DEC_MASK_C) == 13'd0);
      addr        = ADDR_W'(row >> LOG2_DECIM) * LINE_W_C + ADDR_W'(col >> LOG2_DECIM);
      frame_start = vs_prev_q & ~vsync_n;
      // A live request kills the write in the same cycle the FSM leaves CAPTURE.
      wr_fire     = (state_q == S_CAPTURE) && act && on_grid &&
                    (wr_cnt_q < DEPTH_C) && !live_pulse;
   end

   // Registered address/strobe outputs and the vsync edge history.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_prev_q  <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         vs_prev_q  <= vsync_n;
         wr_en_q    <= wr_fire;
         wr_addr_q  <= addr;
         rd_addr_q  <= addr;
         rd_valid_q <= act;
      end
   end

   // Next state, write counter, capture counter and short-frame flag.
   // A live edge always wins over a capture edge or a frame end.
   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      frame_cnt_d = frame_cnt_q;
      short_d     = short_q;
      wr_cnt_inc  = wr_cnt_q + CNT_W'(wr_fire);
      case (state_q)
         S_LIVE: begin
            if (cap_pulse && !live_pulse) state_d = S_ARM;
         end
         S_ARM: begin
            if (live_pulse) begin
               state_d = S_LIVE;
            end else if (frame_start) begin
               state_d  = S_CAPTURE;
               wr_cnt_d = '0;
               short_d  = 1'b0;
            end
         end
         S_CAPTURE: begin
            wr_cnt_d = wr_cnt_inc;
            if (live_pulse) begin
               state_d = S_LIVE;
            end else if (wr_cnt_inc == DEPTH_C) begin
               // Covers a frame start coinciding with the last write: full frame.
               state_d     = S_FROZEN;
               frame_cnt_d = frame_cnt_q + 8'd1;
               short_d     = 1'b0;
            end else if (frame_start) begin
               state_d     = S_FROZEN;
               frame_cnt_d = frame_cnt_q + 8'd1;
               short_d     = 1'b1;
            end
         end
         S_FROZEN: begin
            if (live_pulse)     state_d = S_LIVE;
            else if (cap_pulse) state_d = S_ARM;
         end
         default: state_d = S_LIVE;
      endcase
   end

   // FSM and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_LIVE;
         wr_cnt_q    <= '0;
         frame_cnt_q <= 8'd0;
         short_q     <= 1'b0;
         freeze_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         short_q     <= short_d;
         freeze_q    <= (state_d == S_FROZEN);
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign rd_addr     = rd_addr_q;
   assign rd_valid    = rd_valid_q;
   assign freeze      = freeze_q;
   assign state       = state_q;
   assign frame_cnt   = frame_cnt_q;
   assign short_frame = short_q;

endmodule : frame_capture_ctrl

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl. Expected write addresses are queued as
// pixels are driven; a negedge monitor pops and compares on every wr_en.
module tb_frame_capture_ctrl;

  localparam logic [12:0] BLANK = 13'd8191;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        vsync_n;
  logic [12:0] row;
  logic [12:0] col;
  logic        capture_req;
  logic        live_req;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [16:0] rd_addr;
  logic        rd_valid;
  logic        freeze;
  logic [1:0]  state;
  logic [7:0]  frame_cnt;
  logic        short_frame;

  frame_capture_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync_n     (vsync_n),
    .row         (row),
    .col         (col),
    .capture_req (capture_req),
    .live_req    (live_req),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .freeze      (freeze),
    .state       (state),
    .frame_cnt   (frame_cnt),
    .short_frame (short_frame)
  );

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp;
  logic [16:0] last_addr;
  int          writes_seen;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every write strobe must match the oldest queued address.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wr_en === 1'b1) begin
      writes_seen++;
      last_addr = wr_addr;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got wr_addr %0d, expected no write", wr_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (wr_addr !== mon_exp) begin
          n_fail++;
          $display("FAIL wr_addr: got %0d, expected %0d", wr_addr, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks return at 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [12:0] r, input logic [12:0] c);
    @(posedge clk);
    #1;
    row = r;
    col = c;
  endtask

  // Present one pixel for exactly one edge; on return the outputs reflect it.
  task automatic pix_once(input logic [12:0] r, input logic [12:0] c);
    set_pix(r, c);
    @(posedge clk);
    #1;
    row = BLANK;
    col = BLANK;
  endtask

  task automatic pulse_capture();
    @(posedge clk);
    #1 capture_req = 1'b1;
    tick(2);
    capture_req = 1'b0;
    tick(6);
  endtask

  task automatic pulse_live();
    @(posedge clk);
    #1 live_req = 1'b1;
    tick(2);
    live_req = 1'b0;
    tick(6);
  endtask

  task automatic pulse_both();
    @(posedge clk);
    #1;
    capture_req = 1'b1;
    live_req    = 1'b1;
    tick(2);
    capture_req = 1'b0;
    live_req    = 1'b0;
    tick(6);
  endtask

  task automatic vsync_pulse();
    @(posedge clk);
    #1 vsync_n = 1'b0;
    tick(2);
    vsync_n = 1'b1;
    tick(2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int seen0;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    writes_seen = 0;
    last_addr   = '0;
    reset_n     = 1'b0;
    vsync_n     = 1'b1;
    row         = BLANK;
    col         = BLANK;
    capture_req = 1'b0;
    live_req    = 1'b0;
    tick(5);
    reset_n = 1'b1;
    tick(3);

    // Reset state
    check("rst_state",     32'(state),       0);
    check("rst_freeze",    32'(freeze),      0);
    check("rst_wr_en",     32'(wr_en),       0);
    check("rst_frame_cnt", 32'(frame_cnt),   0);
    check("rst_short",     32'(short_frame), 0);
    check("rst_rd_valid",  32'(rd_valid),    0);

    // Capture request arms; no writes while waiting for frame start
    pulse_capture();
    check("arm_state",  32'(state),  1);
    check("arm_freeze", 32'(freeze), 0);
    pix_once(13'd0, 13'd0);
    check("arm_no_wr",    32'(wr_en),    0);
    check("arm_hold",     32'(state),    1);
    check("arm_rd_addr",  32'(rd_addr),  0);
    check("arm_rd_valid", 32'(rd_valid), 1);

    // Frame start -> CAPTURE, then one full decimated frame
    vsync_pulse();
    check("cap_state", 32'(state), 2);
    seen0 = writes_seen;
    for (int r = 0; r < 480; r += 2) begin
      for (int c = 0; c < 640; c += 2) begin
        set_pix(13'(r), 13'(c));
        exp_q.push_back(17'((r / 2) * 320 + (c / 2)));
      end
    end
    set_pix(BLANK, BLANK);
    tick(3);
    check("full_writes",    32'(writes_seen - seen0), 76800);
    check("full_last_addr", 32'(last_addr),           76799);
    check("full_state",     32'(state),               3);
    check("full_freeze",    32'(freeze),              1);
    check("full_frame_cnt", 32'(frame_cnt),           1);
    check("full_short",     32'(short_frame),         0);
    check("full_wr_idle",   32'(wr_en),               0);

    // Recapture from FROZEN and directed address checks
    pulse_capture();
    check("recap_state",     32'(state),     1);
    check("recap_freeze",    32'(freeze),    0);
    check("recap_frame_cnt", 32'(frame_cnt), 1);
    vsync_pulse();
    check("recap_cap", 32'(state), 2);

    pix_once(13'd3, 13'd5);
    check("odd_rd_addr",  32'(rd_addr),  322);
    check("odd_rd_valid", 32'(rd_valid), 1);
    check("odd_wr_en",    32'(wr_en),    0);
    pix_once(13'd3, 13'd3);
    check("odd2_rd_addr", 32'(rd_addr), 321);
    exp_q.push_back(17'd322);
    pix_once(13'd2, 13'd4);
    check("even_wr_en",   32'(wr_en),   1);
    check("even_wr_addr", 32'(wr_addr), 322);
    check("even_rd_addr", 32'(rd_addr), 322);
    pix_once(13'd2, BLANK);
    check("colwrap_rd_valid", 32'(rd_valid), 0);
    check("colwrap_wr_en",    32'(wr_en),    0);
    pix_once(BLANK, 13'd4);
    check("rowwrap_rd_valid", 32'(rd_valid), 0);
    check("rowwrap_wr_en",    32'(wr_en),    0);
    pix_once(13'd480, 13'd0);
    check("row480_rd_valid", 32'(rd_valid), 0);
    pix_once(13'd0, 13'd640);
    check("col640_rd_valid", 32'(rd_valid), 0);
    pix_once(13'd479, 13'd639);
    check("corner_rd_valid", 32'(rd_valid), 1);
    check("corner_rd_addr",  32'(rd_addr),  76799);
    check("corner_wr_en",    32'(wr_en),    0);

    // Abort mid-capture: only pixels sampled before the live pulse lands write
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) live_req = 1'b1;
      if (k == 4) live_req = 1'b0;
      row = 13'd10;
      col = 13'(2 * k);
      if (k < 3) exp_q.push_back(17'(1600 + k));
    end
    set_pix(BLANK, BLANK);
    tick(3);
    check("abort_state",     32'(state),     0);
    check("abort_freeze",    32'(freeze),    0);
    check("abort_frame_cnt", 32'(frame_cnt), 1);
    check("abort_drained",   32'(exp_q.size()), 0);

    // Short frame: frame start after 1000 writes
    pulse_capture();
    check("short_arm", 32'(state), 1);
    vsync_pulse();
    check("short_cap", 32'(state), 2);
    for (int i = 0; i < 1000; i++) begin
      set_pix(13'(2 * (i / 320)), 13'(2 * (i % 320)));
      exp_q.push_back(17'(i));
    end
    set_pix(BLANK, BLANK);
    tick(2);
    check("short_still_cap", 32'(state), 2);
    vsync_pulse();
    check("short_state",     32'(state),       3);
    check("short_flag",      32'(short_frame), 1);
    check("short_frame_cnt", 32'(frame_cnt),   2);
    check("short_freeze",    32'(freeze),      1);

    // Simultaneous capture and live in FROZEN: live wins
    pulse_both();
    check("both_state",     32'(state),       0);
    check("both_freeze",    32'(freeze),      0);
    check("both_frame_cnt", 32'(frame_cnt),   2);
    check("both_short",     32'(short_frame), 1);

    // short_frame clears only when a new capture starts
    pulse_capture();
    check("clr_arm_short", 32'(short_frame), 1);
    vsync_pulse();
    check("clr_cap_state", 32'(state),       2);
    check("clr_cap_short", 32'(short_frame), 0);
    pulse_live();
    check("clr_live_state", 32'(state),     0);
    check("clr_frame_cnt",  32'(frame_cnt), 2);

    tick(4);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_frame_capture_ctrl
